display_channel_selector: RTL
=============================

DISPLAY_CHANNEL_SELECTOR -- requirements
Module: display_channel_selector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of each channel in bits.
REQ-002 The block SHALL have parameter NCH, default 4, giving the number of channels (range 2..16).
REQ-003 The block SHALL have parameter DWELL, default 50_000_000, giving the number of clock cycles each channel is shown in auto mode (DWELL >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data_in, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port sel, input, $clog2(NCH) bits: the requested channel for a manual load.
REQ-008 The block SHALL have port sel_load, input, 1 bit: a one-cycle strobe that commits sel.
REQ-009 The block SHALL have port auto_en, input, 1 bit: level signal, 1 = auto-scan mode, 0 = manual mode.
REQ-010 The block SHALL have port freeze, input, 1 bit: level signal that holds to_display (present only when DISPLAY_HOLD_EN is defined).
REQ-011 The block SHALL have port to_display, output, WIDTH bits: the registered value of the selected channel.
REQ-012 The block SHALL have port cur_ch, output, $clog2(NCH) bits: the registered index of the active channel.
REQ-013 The block SHALL have port ch_change, output, 1 bit: a one-cycle pulse in the cycle after cur_ch takes a new value.

Function
REQ-014 The block SHALL implement a two-state FSM with states MANUAL and AUTO.
- MANUAL -> AUTO when auto_en = 1.
- AUTO -> MANUAL when auto_en = 0.
- The transition takes effect on the edge that samples auto_en.
REQ-015 In MANUAL, the block SHALL leave cur_ch unchanged except on sel_load = 1, when cur_ch SHALL take sel on that edge.
REQ-016 The block SHALL ignore sel_load when sel >= NCH: cur_ch is unchanged and no ch_change pulse is produced.
REQ-017 The block SHALL contain a dwell counter of width $clog2(DWELL) that counts 0..DWELL-1 only in AUTO and is held at 0 in MANUAL.
REQ-018 In AUTO, when the dwell counter equals DWELL-1, the block SHALL advance cur_ch to cur_ch+1, wrapping from NCH-1 to 0, and SHALL clear the counter.
REQ-019 When sel_load and a dwell terminal count occur in the same cycle in AUTO, sel_load SHALL take priority:
- cur_ch takes sel;
- the counter clears;
- exactly one ch_change pulse results.
REQ-020 On entry to AUTO, the dwell counter SHALL start at 0 and scanning SHALL begin from the current cur_ch.
REQ-021 On each edge, to_display SHALL register data_in[next_cur_ch*WIDTH +: WIDTH], where next_cur_ch is the value cur_ch takes on that edge.
- Latency from data_in or a channel change to to_display is one cycle.
- to_display and cur_ch always correspond.
REQ-022 The block SHALL assert ch_change for exactly one cycle whenever cur_ch changes value. A load of the already-active channel SHALL produce no pulse.
REQ-023 Changing auto_en SHALL neither alter cur_ch nor produce a ch_change pulse.

Reset
REQ-024 While reset_n = 0, the block SHALL asynchronously force the following, independent of clk:
- FSM = MANUAL;
- cur_ch = 0;
- dwell counter = 0;
- to_display = 0;
- ch_change = 0.
REQ-025 After reset_n deasserts, the first active edge SHALL follow REQ-014..REQ-023 normally, including loading data_in channel 0 into to_display.
REQ-026 A reset asserted mid-dwell or mid-freeze SHALL discard all progress, and no ch_change pulse SHALL be generated by the reset itself.

Configuration
REQ-027 The feature macro SHALL be named DISPLAY_HOLD_EN.
REQ-028 With DISPLAY_HOLD_EN defined:
- While freeze = 1, to_display SHALL hold its value.
- cur_ch, the dwell counter and ch_change SHALL continue to operate.
- On the first edge with freeze = 0, to_display SHALL reload from the current channel.
REQ-029 With DISPLAY_HOLD_EN undefined, the freeze port SHALL be absent and to_display SHALL always follow REQ-021.

Verification
REQ-030 The bench SHALL cover a manual load with WIDTH=16, NCH=4, ch2 = 16'hBEEF:
- Stimulus: sel=2 with a one-cycle sel_load.
- Next cycle: cur_ch=2, to_display=16'hBEEF, ch_change=1 for exactly one cycle.
REQ-031 The bench SHALL cover auto wrap with DWELL=4, auto_en=1 from cur_ch=3:
- After 4 cycles: cur_ch=0 with one ch_change pulse.
- After 4 more cycles: cur_ch=1.
REQ-032 The bench SHALL cover simultaneous events with DWELL=4 in AUTO:
- Stimulus: sel_load with sel=1 on the terminal-count cycle while cur_ch=2.
- Response: cur_ch=1 (not 3), a single ch_change pulse, then the next advance 4 cycles later.
REQ-033 The bench SHALL cover an invalid select with NCH=3 (sel is 2 bits):
- Stimulus: sel=3 with sel_load.
- Response: cur_ch unchanged and ch_change=0.
REQ-034 The bench SHALL cover freeze with DISPLAY_HOLD_EN defined:
- Stimulus: freeze=1 while to_display=16'h1234; change data_in ch0 to 16'h5678.
- Response: to_display stays 16'h1234; one cycle after freeze=0, to_display=16'h5678.
REQ-035 The bench SHALL cover reset mid-operation:
- Stimulus: assert reset_n=0 asynchronously, between edges, during AUTO with cur_ch=2.
- Response: to_display=0, cur_ch=0 and state=MANUAL immediately, before the next edge.

Source files
------------

// File: rtl/display_channel_selector.sv
// Display channel selector: manual or auto-scan selection of one of NCH channels onto a registered display bus.
// Optional feature macro DISPLAY_HOLD_EN adds a freeze input that holds to_display while cur_ch keeps moving.
module display_channel_selector #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NCH*WIDTH-1:0]    data_in,
  input  logic [$clog2(NCH)-1:0]  sel,
  input  logic                    sel_load,
  input  logic                    auto_en,
`ifdef DISPLAY_HOLD_EN
  input  logic                    freeze,
`endif
  output logic [WIDTH-1:0]        to_display,
  output logic [$clog2(NCH)-1:0]  cur_ch,
  output logic                    ch_change
);

  localparam int SELW = $clog2(NCH);
  localparam int CNTW = $clog2(DWELL);
  localparam logic [SELW:0]   NCH_EXT  = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0]   cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0]  to_display_q, to_display_d;
  logic              ch_change_q, ch_change_d;
  logic              loadValid;
  logic              scanActive;

  // Scanning needs both the registered state and the live level, so the exit edge neither counts nor advances.
  always_comb begin
    state_d    = auto_en ? AUTO : MANUAL;
    cur_ch_d   = cur_ch_q;
    cnt_d      = '0;
    loadValid  = sel_load && ({1'b0, sel} < NCH_EXT);
    scanActive = (state_q == AUTO) && auto_en;

    if (scanActive) begin
      if (cnt_q == CNT_LAST) begin
        cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (loadValid) begin
      cur_ch_d = sel;
      cnt_d    = '0;
    end

    to_display_d = data_in[int'(cur_ch_d)*WIDTH +: WIDTH];
`ifdef DISPLAY_HOLD_EN
    if (freeze) begin
      to_display_d = to_display_q;
    end
`endif
    ch_change_d = (cur_ch_d != cur_ch_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MANUAL;
      cnt_q        <= '0;
      cur_ch_q     <= '0;
      to_display_q <= '0;
      ch_change_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_ch_q     <= cur_ch_d;
      to_display_q <= to_display_d;
      ch_change_q  <= ch_change_d;
    end
  end

  assign to_display = to_display_q;
  assign cur_ch     = cur_ch_q;
  assign ch_change  = ch_change_q;

endmodule
